approx_err_monitor: RTL

- Synthesizable, streaming error-metric engine for approximate-adder characterisation.
- Each beat supplies an exact reference sum and an approximate sum.
- Block accumulates error count, error-distance sum and maximum error distance over a programmed sample count.
- Sits beside a DUT adder and its exact reference on the evaluation fabric; replaces host-side metric computation, leaving MED/NMED/ER as simple host divisions.

---
 rtl/approx_err_pkg.sv | 11 +
 rtl/approx_err_abs_diff.sv | 16 +
 rtl/approx_err_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/approx_err_pkg.sv
// Shared types for the approximate-adder error monitor.
package approx_err_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // The error-distance sum must hold (2^cnt_w - 1) * 2^n without wrapping.
    function automatic int ed_sum_width(input int n, input int cnt_w);
        return n + 1 + cnt_w;
    endfunction

endpackage

// File: rtl/approx_err_abs_diff.sv
// Combinational unsigned |a - b| and inequality flag over full {Co,S} sums.
module approx_err_abs_diff #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         ne
);

    always_comb begin
        ne   = (a != b);
        diff = (a >= b) ? (a - b) : (b - a);
    end

endmodule

// File: rtl/approx_err_monitor.sv
// Streaming error-metric accumulator for approximate adders.
// Optional APPROX_ERR_MON_MSE_EN adds a registered squarer and ed_sq_sum (latency 3).
module approx_err_monitor
    import approx_err_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  cfg_samples,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N:0]                        exact_s,
    input  logic [N:0]                        approx_s,
    output logic                              busy,
    output logic                              done,
    output logic [CNT_W-1:0]                  sample_count,
    output logic [CNT_W-1:0]                  err_count,
    output logic [ed_sum_width(N, CNT_W)-1:0] ed_sum,
    output logic [N:0]                        max_ed
`ifdef APPROX_ERR_MON_MSE_EN
    ,
    output logic [2*(N+1)+CNT_W-1:0]          ed_sq_sum
`endif
);

    localparam int W        = N + 1;
    localparam int ED_SUM_W = ed_sum_width(N, CNT_W);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target, accepted;
    logic             accept, last_accept, last_update;
    logic [W-1:0]     ed;
    logic             mis;
    logic             s1_vld, s1_mis;
    logic [W-1:0]     s1_ed;
    logic             acc_vld, acc_mis;
    logic [W-1:0]     acc_ed;

    approx_err_abs_diff #(.W(W)) u_abs (
        .a    (approx_s),
        .b    (exact_s),
        .diff (ed),
        .ne   (mis)
    );

    assign in_ready    = (state_q == RUN) && (accepted < target) && !start;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (accepted + CNT_W'(1) == target);
    assign last_update = acc_vld && (sample_count + CNT_W'(1) == target);
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (cfg_samples == '0) ? DONE : RUN;
        end else begin
            case (state_q)
                RUN:     if (last_accept) state_d = DRAIN;
                DRAIN:   if (last_update) state_d = DONE;
                default: ;
            endcase
        end
    end

    // start wins over everything: in-flight beats and partial sums are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target       <= '0;
            accepted     <= '0;
            s1_vld       <= 1'b0;
            s1_ed        <= '0;
            s1_mis       <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            max_ed       <= '0;
        end else if (start) begin
            target       <= cfg_samples;
            accepted     <= '0;
            s1_vld       <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            max_ed       <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                accepted <= accepted + CNT_W'(1);
                s1_ed    <= ed;
                s1_mis   <= mis;
            end
            if (acc_vld) begin
                sample_count <= sample_count + CNT_W'(1);
                err_count    <= err_count + CNT_W'(acc_mis);
                ed_sum       <= ed_sum + ED_SUM_W'(acc_ed);
                if (acc_ed > max_ed) max_ed <= acc_ed;
            end
        end
    end

`ifdef APPROX_ERR_MON_MSE_EN
    localparam int SQ_W     = 2 * W;
    localparam int SQ_SUM_W = SQ_W + CNT_W;

    logic             s2_vld, s2_mis;
    logic [W-1:0]     s2_ed;
    logic [SQ_W-1:0]  s2_sq;

    // Extra register stage holds the squarer output; all metrics move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_mis <= 1'b0;
            s2_ed  <= '0;
            s2_sq  <= '0;
        end else if (start) begin
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_mis <= s1_mis;
                s2_ed  <= s1_ed;
                s2_sq  <= SQ_W'(s1_ed) * SQ_W'(s1_ed);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ed_sq_sum <= '0;
        else if (start)   ed_sq_sum <= '0;
        else if (acc_vld) ed_sq_sum <= ed_sq_sum + SQ_SUM_W'(s2_sq);
    end

    assign acc_vld = s2_vld;
    assign acc_ed  = s2_ed;
    assign acc_mis = s2_mis;
`else
    assign acc_vld = s1_vld;
    assign acc_ed  = s1_ed;
    assign acc_mis = s1_mis;
`endif

endmodule
